// File: rtl/uart_aes_pkg.sv
// Types and constants shared by the UART receive path and the AES-CTR/TX controller.
package uart_aes_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_BLOCK_BITS  = 128;

  typedef enum logic [0:0] {
    ST_COLLECT,
    ST_FULL
  } asm_state_t;

endpackage : uart_aes_pkg

// File: rtl/uart_idle_timer.sv
// Idle-cycle counter: counts enabled cycles and pulses expire_o once CYCLES is reached.
module uart_idle_timer
  import uart_aes_pkg::*;
#(
  parameter int unsigned CYCLES = 8680,
  parameter int unsigned CNT_W  = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  // A zero limit means the timer never fires.
  assign expire_o = (CYCLES != 0) && enable_i && !clear_i && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (enable_i && (count_q < LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : uart_idle_timer

// File: rtl/uart_rx_block_assembler.sv
// Packs UART bytes MSB-first into 128-bit blocks behind a one-deep valid/ready output register.
module uart_rx_block_assembler
  import uart_aes_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8680,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      flush,
  output logic [AES_BLOCK_BITS-1:0] block_data,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [4:0]                byte_count,
  output logic                      timeout_err,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count
);

  if (BLOCK_BYTES != AES_BLOCK_BYTES) begin : g_bad_block_bytes
    $error("uart_rx_block_assembler: BLOCK_BYTES must be 16");
  end

  localparam logic [4:0] LAST_IDX = 5'(AES_BLOCK_BYTES - 1);
  localparam logic [4:0] FULL_CNT = 5'(AES_BLOCK_BYTES);

  asm_state_t                state_q, state_d;
  logic [AES_BLOCK_BITS-1:0] asm_q, asm_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [AES_BLOCK_BITS-1:0] blk_q;
  logic                      valid_q;
  logic                      timeout_q;
  logic                      overflow_q;
  logic [CNT_W-1:0]          drop_q;

  logic                      slot_free;
  logic [AES_BLOCK_BITS-1:0] ins_word;
  logic                      load_out;
  logic [AES_BLOCK_BITS-1:0] load_word;
  logic                      drop;
  logic                      tmo_evt;
  logic                      tmr_clear;
  logic                      tmr_enable;
  logic                      tmr_expire;

  assign slot_free = !valid_q || block_ready;

  assign tmr_clear  = rx_valid || flush || (cnt_q == '0) || (state_q != ST_COLLECT);
  assign tmr_enable = (state_q == ST_COLLECT) && (cnt_q != '0);

  uart_idle_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expire_o (tmr_expire)
  );

  // Assembly word with the incoming byte dropped into slot byte_count.
  always_comb begin
    ins_word = asm_q;
    for (int unsigned i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (cnt_q == 5'(i)) begin
        ins_word[AES_BLOCK_BITS-1-8*i -: 8] = rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (!flush && rx_valid && (cnt_q == LAST_IDX) && !slot_free) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (flush || slot_free) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    load_out  = 1'b0;
    load_word = asm_q;
    drop      = 1'b0;
    tmo_evt   = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (flush) begin
          asm_d = '0;
          cnt_d = '0;
        end else if (rx_valid) begin
          if (cnt_q != LAST_IDX) begin
            asm_d = ins_word;
            cnt_d = cnt_q + 1'b1;
          end else if (slot_free) begin
            load_out  = 1'b1;
            load_word = ins_word;
            asm_d     = '0;
            cnt_d     = '0;
          end else begin
            asm_d = ins_word;
            cnt_d = FULL_CNT;
          end
        end else if (tmr_expire) begin
          asm_d   = '0;
          cnt_d   = '0;
          tmo_evt = 1'b1;
        end
      end
      ST_FULL: begin
        if (flush) begin
          asm_d = '0;
          cnt_d = '0;
        end else begin
          // The held byte is dropped even in the cycle the full block moves out.
          drop = rx_valid;
          if (slot_free) begin
            load_out  = 1'b1;
            load_word = asm_q;
            asm_d     = '0;
            cnt_d     = '0;
          end
        end
      end
      default: begin
        asm_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      blk_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      timeout_q  <= tmo_evt;
      overflow_q <= drop;
      if (load_out) begin
        blk_q   <= load_word;
        valid_q <= 1'b1;
      end else if (valid_q && block_ready) begin
        valid_q <= 1'b0;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign block_data  = blk_q;
  assign block_valid = valid_q;
  assign byte_count  = cnt_q;
  assign timeout_err = timeout_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule : uart_rx_block_assembler

// File: tb/tb_uart_rx_block_assembler.sv
// Directed scoreboard bench for uart_rx_block_assembler.
module tb_uart_rx_block_assembler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         flush;
  logic [127:0] block_data;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   byte_count;
  logic         timeout_err;
  logic         overflow;
  logic [7:0]   drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;
  int tmo_seen = 0;

  logic [127:0] sb[$];
  logic         hold_prev = 1'b0;
  logic [127:0] prev_data = '0;

  localparam logic [127:0] B1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B2 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] B3 = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] B4 = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] B5 = 128'h404142434445464748494A4B4C4D4E4F;
  localparam logic [127:0] B6 = 128'hAAABACADAEAFB0B1B2B3B4B5B6B7B8B9;
  localparam logic [127:0] B7 = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] B8 = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
  localparam logic [127:0] B9 = 128'h707172737475767778797A7B7C7D7E7F;

  always #5 clk = ~clk;

  uart_rx_block_assembler #(
    .BLOCK_BYTES    (16),
    .TIMEOUT_CYCLES (8680),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .flush       (flush),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_count  (byte_count),
    .timeout_err (timeout_err),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: consumes one expected block per handshake and watches the hold rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && block_valid) chk("hold_stable", block_data, prev_data);
      if (overflow) ovf_seen++;
      if (timeout_err) tmo_seen++;
      if (block_valid && block_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_block: got %h expected no block", block_data);
        end else begin
          chk("block_data", block_data, sb.pop_front());
        end
      end
      hold_prev = block_valid && !block_ready;
      prev_data = block_data;
    end
  end

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) strobe(8'(start + i));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf0, tmo0;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; flush = 1'b0; block_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", block_valid, 0);
    chk("rst_data", block_data, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pulses", {overflow, timeout_err}, 0);
    rst_n = 1'b1;
    idle(1);

    // Basic block, ready high: valid one cycle after the 16th byte.
    block_ready = 1'b1;
    sb.push_back(B1);
    send_seq(8'h00, 16);
    chk("lat_valid", block_valid, 1);
    chk("lat_data", block_data, B1);
    chk("lat_count", byte_count, 0);
    idle(2);
    chk("b1_consumed", block_valid, 0);

    // Back-pressure: two blocks buffered, then drained with no gap.
    block_ready = 1'b0;
    sb.push_back(B2);
    sb.push_back(B3);
    send_seq(8'h10, 32);
    chk("full_count", byte_count, 16);
    chk("held_data", block_data, B2);
    block_ready = 1'b1;
    idle(1);
    chk("nogap_valid", block_valid, 1);
    chk("nogap_data", block_data, B3);
    chk("nogap_count", byte_count, 0);
    idle(1);
    chk("drain_valid", block_valid, 0);
    chk("drop_zero", drop_count, 0);

    // Overflow and saturation of the drop counter.
    block_ready = 1'b0;
    sb.push_back(B4);
    sb.push_back(B5);
    send_seq(8'h30, 32);
    ovf0 = ovf_seen;
    send_seq(8'hE0, 3);
    idle(2);
    chk("ovf_pulses", ovf_seen - ovf0, 3);
    chk("drop3", drop_count, 3);
    chk("ovf_held", block_data, B4);
    chk("ovf_count", byte_count, 16);
    send_seq(8'h00, 300);
    idle(2);
    chk("drop_sat", drop_count, 8'hFF);
    chk("sat_pulses", ovf_seen - ovf0, 303);
    block_ready = 1'b1;
    idle(3);

    // Timeout on a partial block.
    tmo0 = tmo_seen;
    send_seq(8'h50, 5);
    idle(8680);
    chk("pre_expiry_count", byte_count, 5);
    idle(5);
    chk("tmo_pulse", tmo_seen - tmo0, 1);
    chk("tmo_count", byte_count, 0);
    sb.push_back(B6);
    send_seq(8'hAA, 16);
    idle(2);

    // Byte at the expiry cycle wins.
    tmo0 = tmo_seen;
    send_seq(8'h60, 5);
    idle(8680);
    strobe(8'h65);
    chk("expiry_byte_count", byte_count, 6);
    idle(3);
    chk("expiry_no_tmo", tmo_seen - tmo0, 0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("flush_clear", byte_count, 0);

    // Flush with a coincident byte, block held at the output.
    block_ready = 1'b0;
    sb.push_back(B7);
    send_seq(8'hC0, 16);
    send_seq(8'hD0, 7);
    ovf0 = ovf_seen;
    tmo0 = tmo_seen;
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'hD7;
    idle(1);
    flush = 1'b0; rx_valid = 1'b0;
    chk("flush_count", byte_count, 0);
    chk("flush_valid", block_valid, 1);
    chk("flush_data", block_data, B7);
    idle(2);
    chk("flush_pulses", (ovf_seen - ovf0) + (tmo_seen - tmo0), 0);
    sb.push_back(B8);
    send_seq(8'hE0, 16);
    chk("post_flush_full", byte_count, 16);
    block_ready = 1'b1;
    idle(3);

    // Asynchronous reset with a block pending.
    block_ready = 1'b0;
    send_seq(8'h80, 16);
    send_seq(8'h90, 3);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", block_valid, 0);
    chk("arst_data", block_data, 0);
    chk("arst_count", byte_count, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_pulses", {overflow, timeout_err}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    sb.push_back(B9);
    send_seq(8'h70, 16);
    chk("post_rst_valid", block_valid, 1);
    chk("post_rst_count", byte_count, 0);
    block_ready = 1'b1;
    idle(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_block_assembler

// File: doc/uart_rx_block_assembler.md
Name: uart_rx_block_assembler

Overview:
- Sits between the UART byte receiver and the AES-CTR encrypt/transmit controller.
- Packs 16 received bytes into one 128-bit plaintext block, MSB-first.
- Presents the block through a valid/ready handshake, so a new block can be assembled while the previous one waits for the AES controller.
- Discards stale partial blocks after an inter-byte timeout and counts bytes dropped on overflow.

Parameters:
- BLOCK_BYTES, 16, bytes per block; fixed at 16, any other value is an elaboration error.
- TIMEOUT_CYCLES, 8680, idle clk cycles allowed between bytes of a partial block (about 2 character times at 50 MHz / 115200); 0 disables the timeout.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe qualifying rx_data.
- flush  in  1  synchronous clear of the partial or held block; does not touch the output register.
- block_data  out  128  assembled plaintext; first byte in [127:120], 16th byte in [7:0].
- block_valid  out  1  block_data holds an unconsumed block.
- block_ready  in  1  consumer accepts the block when block_valid && block_ready.
- byte_count  out  5  bytes currently in the assembly register, 0..16.
- timeout_err  out  1  one-cycle pulse when a partial block is discarded on timeout.
- overflow  out  1  one-cycle pulse for each byte dropped.
- drop_count  out  CNT_W  saturating count of dropped bytes.

Behaviour:
- Reset: all outputs 0; assembly register 0; idle counter 0; state ST_COLLECT. Reset mid-block discards all content, including an un-handshaken output block.
- Output slot is free in a cycle when (!block_valid || block_ready).
- Output register:
  - block_valid sets on a load and clears on a handshake with no simultaneous load.
  - A load in the handshake cycle keeps block_valid=1 and presents the new data the next cycle.
  - block_data is stable while block_valid && !block_ready.
- ST_COLLECT:
  - rx_valid with byte_count=N<15: byte goes to assembly[127-8N -: 8]; byte_count<=N+1; idle counter<=0.
  - rx_valid with N=15, slot free: the full 128-bit word (including this byte) loads block_data next cycle; block_valid=1; byte_count<=0. Latency is 1 cycle from the 16th strobe to block_valid.
  - rx_valid with N=15, slot not free: the byte is stored; byte_count<=16; go to ST_FULL.
- ST_FULL:
  - Any rx_valid drops the byte, including in the transfer cycle: overflow pulses and drop_count increments, saturating at all-ones.
  - When the slot frees, the assembly register loads into the output; byte_count<=0; return to ST_COLLECT.
- Timeout (ST_COLLECT only, byte_count>0, TIMEOUT_CYCLES>0):
  - The idle counter increments on each cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES: byte_count<=0, assembly cleared, idle counter<=0, timeout_err pulses.
  - rx_valid in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
  - The idle counter holds at 0 while byte_count=0.
- flush:
  - Highest priority over rx_valid and timeout: byte_count<=0, assembly cleared, state<=ST_COLLECT, idle counter<=0, no pulses.
  - A byte strobed in the flush cycle is discarded silently.
  - The output register and its handshake are unaffected.
- Arithmetic:
  - Idle counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - byte_count never exceeds 16.
  - drop_count never wraps.

Decomposition:
- Shared package uart_aes_pkg holds:
  - typedef enum logic [0:0] {ST_COLLECT, ST_FULL} asm_state_t;
  - localparam AES_BLOCK_BYTES = 16 and AES_BLOCK_BITS = 128, reused by the AES-CTR/TX controller.
- One natural sub-module: uart_idle_timer, a parameterised counter with clear, enable and expire-pulse outputs, reusable for TX-side watchdogs.
- Byte packing and the output register stay inline.

Test Plan:
- Bytes 00..0F, block_ready=1 -> block_valid high 1 cycle after byte 0F; block_data=128'h000102030405060708090A0B0C0D0E0F; byte_count=0.
- block_ready=0, send 32 bytes 10..2F -> first block 1011..1F held; bytes 20..2F fill the assembly register, byte_count=16. Raise ready -> 2nd block 2021..2F follows with no gap; drop_count=0.
- Hold block_ready=0 with both slots full, send 3 more bytes -> overflow pulses 3 times; drop_count=3; held blocks unchanged. Repeat 300 drops -> drop_count saturates at 8'hFF.
- Send 5 bytes, then idle 8680 cycles -> timeout_err pulses once; byte_count=0. Send 16 fresh bytes AA.. -> block starts with AA at [127:120]. Byte arriving exactly at the expiry cycle -> no timeout; byte_count=6.
- Send 7 bytes, pulse flush with rx_valid the same cycle -> byte_count=0; no pulses; prior block_valid/block_data untouched.
- Assert rst_n=0 asynchronously mid-block with block_valid=1 -> all outputs 0 immediately. After release, 16 bytes give a correct block.
